// File: rtl/gf233_pkg.sv
// Shared constants and state encoding for the word-serial GF(2^233) multiplier.
package gf233_pkg;

  localparam int M        = 233;
  localparam int K        = 74;
  localparam int W        = 16;
  localparam int NW       = 15;
  localparam int ACCW     = 480;
  localparam int LAST_IDX = 14;

  // Operands are zero-padded to a whole number of 16-bit words.
  localparam int PADW = NW * W;

  // After the first fold the highest possible coefficient is x^(M-2+K).
  localparam int F1_TOP = M - 2 + K;
  localparam int H2W    = F1_TOP - M + 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FOLD1,
    FOLD2
  } state_t;

endpackage

// File: rtl/sb16.sv
// Combinational 16x16 carry-less (GF(2)[x]) multiplier producing a 31-bit product.
module sb16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [30:0] p
);

  // Shift-and-XOR over the bits of b; no carries propagate in GF(2).
  always_comb begin
    p = '0;
    for (int k = 0; k < 16; k++) begin
      if (b[k]) p = p ^ ({15'b0, a} << k);
    end
  end

endmodule

// File: rtl/gf233_serial_mul.sv
// Word-serial GF(2^233) multiplier: one 16x16 carry-less product per cycle into a
// 480-bit accumulator, followed by two folds modulo x^233 + x^74 + 1.
module gf233_serial_mul
  import gf233_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [232:0] a,
  input  logic [232:0] b,
  output logic         busy,
  output logic         done,
  output logic [232:0] c
);

  state_t state;
  state_t state_next;

  logic [PADW-1:0]  a_reg;
  logic [PADW-1:0]  b_reg;
  logic [ACCW-1:0]  acc;
  logic [3:0]       i_idx;
  logic [3:0]       j_idx;
  logic [W-1:0]     a_word;
  logic [W-1:0]     b_word;
  logic [2*W-2:0]   p;
  logic             last_pair;
  logic [8:0]       shamt;
  logic [ACCW-1:0]  pp_shifted;
  logic [ACCW-M-1:0] h1;
  logic [ACCW-1:0]  fold1;
  logic [H2W-1:0]   h2;
  logic [M-1:0]     fold2;

  assign a_word    = a_reg[{i_idx, 4'b0000} +: W];
  assign b_word    = b_reg[{j_idx, 4'b0000} +: W];
  assign last_pair = (i_idx == 4'(LAST_IDX)) && (j_idx == 4'(LAST_IDX));

  // Word pair (i, j) lands at bit offset 16*(i+j) in the accumulator.
  assign shamt      = {({1'b0, i_idx} + {1'b0, j_idx}), 4'b0000};
  assign pp_shifted = {{(ACCW-(2*W-1)){1'b0}}, p} << shamt;

  // x^233 == x^74 + 1, so every coefficient at or above 233 is folded back twice down.
  // h1 spans the whole upper accumulator; its top bits are always zero for valid products.
  assign h1    = acc[ACCW-1:M];
  assign fold1 = {{(ACCW-M){1'b0}}, acc[M-1:0]}
               ^ {{M{1'b0}}, h1}
               ^ ({{M{1'b0}}, h1} << K);

  assign h2    = acc[F1_TOP:M];
  assign fold2 = acc[M-1:0]
               ^ {{(M-H2W){1'b0}}, h2}
               ^ ({{(M-H2W){1'b0}}, h2} << K);

  sb16 u_sb16 (
    .a (a_word),
    .b (b_word),
    .p (p)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: fixed sequence of 225 multiply cycles and two fold cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MUL;
      MUL:     if (last_pair) state_next = FOLD1;
      FOLD1:   state_next = FOLD2;
      FOLD2:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, word counters, accumulation, folds and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= {{(PADW-M){1'b0}}, a};
            b_reg <= {{(PADW-M){1'b0}}, b};
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            busy  <= 1'b1;
          end
        end
        MUL: begin
          acc <= acc ^ pp_shifted;
          if (last_pair) begin
            i_idx <= '0;
            j_idx <= '0;
          end else if (j_idx == 4'(LAST_IDX)) begin
            j_idx <= '0;
            i_idx <= i_idx + 4'd1;
          end else begin
            j_idx <= j_idx + 4'd1;
          end
        end
        FOLD1: begin
          acc <= fold1;
        end
        FOLD2: begin
          c    <= fold2;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf233_serial_mul.sv
// Scoreboard-driven bench for the word-serial GF(2^233) multiplier.
module tb_gf233_serial_mul;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [232:0] a;
  logic [232:0] b;
  logic         busy;
  logic         done;
  logic [232:0] c;

  int checks = 0;
  int passed = 0;
  logic [232:0] sb_q[$];

  localparam int LATENCY = 228;
  localparam int TIMEOUT = 400;

  always #5 clk = ~clk;

  gf233_serial_mul dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  // Reference: bit-serial shift-and-add with reduction by x^233 = x^74 + 1 at every shift.
  function automatic logic [232:0] model_mul(input logic [232:0] x, input logic [232:0] y);
    logic [232:0] r;
    logic [232:0] s;
    logic         carry;
    r = '0;
    s = x;
    for (int k = 0; k < 233; k++) begin
      if (y[k]) r = r ^ s;
      carry = s[232];
      s = s << 1;
      if (carry) begin
        s[74] = s[74] ^ 1'b1;
        s[0]  = s[0] ^ 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [232:0] rand233();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
    return t[232:0];
  endfunction

  function automatic logic [232:0] pop_expected();
    if (sb_q.size() > 0) return sb_q.pop_front();
    return 'x;
  endfunction

  // Drive one start pulse (accepted at the next rising edge), push the expected result,
  // then scramble the operand inputs to show they are not needed after acceptance.
  task automatic issue(input logic [232:0] x, input logic [232:0] y, input logic [232:0] expv);
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    a = rand233();
    b = rand233();
  endtask

  // n counts rising edges since and including the accept edge.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    checks++; if (c !== '0) $display("[TB] FAIL reset_c: got %h expected 0", c); else passed++;
  endtask

  task automatic test_one_times_one();
    logic [232:0] one;
    logic [232:0] expv;
    logic [232:0] got;
    int n;
    bit busy_ok;
    one = '0;
    one[0] = 1'b1;
    issue(one, one, one);
    busy_ok = 1'b1;
    n = 1;
    while (!done && n < TIMEOUT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    expv = pop_expected();
    checks++; if (n != LATENCY) $display("[TB] FAIL one_latency: got %0d expected %0d", n, LATENCY); else passed++;
    checks++; if (!busy_ok) $display("[TB] FAIL one_busy_window: got low expected high"); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL one_busy_done_cycle: got %b expected 0", busy); else passed++;
    checks++; if (c !== expv) $display("[TB] FAIL one_result: got %h expected %h", c, expv); else passed++;
    got = c;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("[TB] FAIL one_done_pulse: got %b expected 0", done); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (c !== expv) $display("[TB] FAIL one_result_hold: got %h expected %h (was %h)", c, expv, got); else passed++;
  endtask

  task automatic test_single_fold();
    logic [232:0] x;
    logic [232:0] y;
    logic [232:0] expv;
    int n;
    x = '0; x[232] = 1'b1;
    y = '0; y[1] = 1'b1;
    expv = '0; expv[74] = 1'b1; expv[0] = 1'b1;
    issue(x, y, expv);
    wait_done(n);
    expv = pop_expected();
    checks++; if (n != LATENCY) $display("[TB] FAIL fold1_latency: got %0d expected %0d", n, LATENCY); else passed++;
    checks++; if (c !== expv) $display("[TB] FAIL fold1_result: got %h expected %h", c, expv); else passed++;
  endtask

  task automatic test_double_fold();
    logic [232:0] x;
    logic [232:0] expv;
    int n;
    x = '0; x[232] = 1'b1;
    expv = '0; expv[231] = 1'b1; expv[146] = 1'b1; expv[72] = 1'b1;
    issue(x, x, expv);
    wait_done(n);
    expv = pop_expected();
    checks++; if (n != LATENCY) $display("[TB] FAIL fold2_latency: got %0d expected %0d", n, LATENCY); else passed++;
    checks++; if (c !== expv) $display("[TB] FAIL fold2_result: got %h expected %h", c, expv); else passed++;
  endtask

  task automatic test_random(input int count);
    logic [232:0] x;
    logic [232:0] y;
    logic [232:0] expv;
    int n;
    int bad_lat;
    bad_lat = 0;
    for (int v = 0; v < count; v++) begin
      case (v)
        0:       begin x = '1; y = '1; end
        1:       begin x = '0; y = rand233(); end
        2:       begin x = '1; y = rand233(); end
        3:       begin x = rand233(); y = '1; end
        default: begin x = rand233(); y = rand233(); end
      endcase
      issue(x, y, (v == 1) ? 233'b0 : model_mul(x, y));
      wait_done(n);
      if (n != LATENCY) bad_lat++;
      expv = pop_expected();
      checks++;
      if (c !== expv) $display("[TB] FAIL random_%0d: got %h expected %h", v, c, expv);
      else passed++;
      @(negedge clk);
    end
    checks++; if (bad_lat != 0) $display("[TB] FAIL random_latency: got %0d wrong expected 0", bad_lat); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [232:0] x1, y1, x2, y2, x3, y3, expv;
    int n;
    x1 = rand233(); y1 = rand233();
    x2 = rand233(); y2 = rand233();
    x3 = rand233(); y3 = rand233();
    issue(x1, y1, model_mul(x1, y1));
    n = 1;
    while (!done && n < TIMEOUT) begin
      start = (n == 50);
      if (n == 50) begin
        a = x2;
        b = y2;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    expv = pop_expected();
    checks++; if (n != LATENCY) $display("[TB] FAIL ignore_latency: got %0d expected %0d", n, LATENCY); else passed++;
    checks++; if (c !== expv) $display("[TB] FAIL ignore_result: got %h expected %h", c, expv); else passed++;
    issue(x3, y3, model_mul(x3, y3));
    wait_done(n);
    expv = pop_expected();
    checks++; if (n != LATENCY) $display("[TB] FAIL b2b_latency: got %0d expected %0d", n, LATENCY); else passed++;
    checks++; if (c !== expv) $display("[TB] FAIL b2b_result: got %h expected %h", c, expv); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [232:0] x, y, expv;
    int n;
    bit seen;
    x = rand233(); y = rand233();
    issue(x, y, model_mul(x, y));
    for (n = 1; n < 100; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL abort_done: got %b expected 0", done); else passed++;
    checks++; if (c !== '0) $display("[TB] FAIL abort_c: got %h expected 0", c); else passed++;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++; if (seen) $display("[TB] FAIL abort_no_done: got done expected none"); else passed++;
    x = rand233(); y = rand233();
    issue(x, y, model_mul(x, y));
    wait_done(n);
    expv = pop_expected();
    checks++; if (n != LATENCY) $display("[TB] FAIL abort_fresh_latency: got %0d expected %0d", n, LATENCY); else passed++;
    checks++; if (c !== expv) $display("[TB] FAIL abort_fresh_result: got %h expected %h", c, expv); else passed++;
  endtask

  initial begin
    test_reset();
    test_one_times_one();
    test_single_fold();
    test_double_fold();
    test_random(150);
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
